clk_period_checker: RTL and testbench
=====================================

CLK_PERIOD_CHECKER -- requirements
Module: clk_period_checker

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter CNT_W, default 16: width of all period and high-time counters and thresholds.
REQ-003 Parameter SYNC_STAGES, default 2 (minimum 2): number of synchronizer flops on mon_clk.
REQ-004 Port clk, input, 1: system clock; every flop is clocked on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port mon_clk, input, 1: monitored clock, asynchronous to clk, treated as data.
REQ-007 Port en, input, 1: measurement enable.
REQ-008 Ports period_min and period_max, input, CNT_W each: inclusive period bounds in clk cycles.
REQ-009 Ports high_min and high_max, input, CNT_W each: inclusive high-time bounds in clk cycles.
REQ-010 Port err_clr, input, 1: clears all sticky error flags.
REQ-011 Port period_cnt, output, CNT_W: last completed period measurement.
REQ-012 Port high_cnt, output, CNT_W: last completed high-time measurement.
REQ-013 Port meas_vld, output, 1: one-cycle pulse when period_cnt and high_cnt update.
REQ-014 Ports err_period, err_high and err_stuck, output, 1 each: sticky error flags.
REQ-015 Port locked, output, 1: high after the first valid measurement completes.

Function
REQ-016 mon_clk SHALL pass through SYNC_STAGES flops; a rise or fall is detected by comparing the last synchronized stage with one extra delay flop.
REQ-017 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-018 IDLE -> ARM when en=1.
REQ-019 ARM -> MEASURE on the first synchronized rise; the partial period before that rise is discarded.
REQ-020 Any state -> IDLE when en=0; locked clears, counters clear, error flags hold.
REQ-021 In MEASURE, the period counter SHALL load 1 on each rise and otherwise increment by 1, saturating at 2^CNT_W-1.
REQ-022 The high counter SHALL increment while the synchronized level is 1, be captured on a fall, and be cleared on a rise.
REQ-023 On a rise in MEASURE, period_cnt and high_cnt SHALL update and meas_vld SHALL pulse in the same cycle as the rise detection; latency from the mon_clk edge is SYNC_STAGES+1 clk cycles.
REQ-024 err_period SHALL set if a captured period is below period_min or above period_max.
REQ-025 err_stuck SHALL set when the period counter saturates; the FSM stays in MEASURE, and the next rise reloads the counter.
REQ-026 If err_clr and a new error occur in the same cycle, the new error SHALL win (flag set).
REQ-027 locked SHALL set on the first in-bounds measurement and clear on any error-setting event.
REQ-028 If min > max for a bound pair, every measurement SHALL set the corresponding error.

Reset
REQ-029 On rst: state=IDLE; synchronizer, counters, period_cnt and high_cnt =0; meas_vld=0; locked=0; all error flags=0.
REQ-030 rst asserted mid-measurement SHALL discard the partial measurement; after release, ARM is re-entered only through IDLE.

Configuration
REQ-031 Macro CLK_PERIOD_CHECKER_DUTY_EN defined: high counter, high_cnt and err_high are implemented as specified.
REQ-032 Macro CLK_PERIOD_CHECKER_DUTY_EN undefined: high_cnt and err_high are tied to 0, high_min and high_max are ignored, and no high-time logic is present.

Structure
REQ-033 Package clk_period_checker_pkg SHALL hold the FSM state enum and the SYNC_STAGES minimum constant.
REQ-034 The synchronizer plus edge detect SHALL be sub-module clk_period_checker_sync, with outputs lvl, rise and fall.

Verification
REQ-035 clk=10ns, mon_clk=100ns 50% duty, bounds 9..11 / 4..6, en=1 -> period_cnt=10, high_cnt=5, locked=1, no errors.
REQ-036 mon_clk held at 0 with CNT_W=8 -> err_stuck set 255 cycles after the last rise; locked=0.
REQ-037 mon_clk period 130ns, bounds 9..11 -> period_cnt=13 and err_period set at the first measured rise; err_clr then clears it.
REQ-038 Duty 30% at 100ns with high bounds 4..6 -> high_cnt=3 and err_high set; with the macro undefined -> err_high stays 0.
REQ-039 rst pulsed mid-high-phase -> all outputs 0 next cycle; the first meas_vld occurs only after two subsequent rises.
REQ-040 err_clr asserted in the same cycle as an out-of-bounds capture -> err_period remains 1.

Source files
------------

// File: rtl/clk_period_checker_pkg.sv
// Shared types and constants for the clock period checker.
package clk_period_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // Clamp a requested synchronizer depth to the safe minimum.
  function automatic int unsigned sync_depth(input int unsigned req);
    return (req < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : req;
  endfunction

endpackage

// File: rtl/clk_period_checker_sync.sv
// Synchronizes the monitored clock into clk and flags its rising/falling edges.
module clk_period_checker_sync
  import clk_period_checker_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int unsigned N = sync_depth(SYNC_STAGES);

  logic [N-1:0] sync_q, sync_d;
  logic         dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], mon_clk};
    dly_d  = sync_q[N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign lvl  = sync_q[N-1];
  assign rise = sync_q[N-1] & ~dly_q;
  assign fall = ~sync_q[N-1] & dly_q;

endmodule

// File: rtl/clk_period_checker.sv
// Measures period and high time of mon_clk in clk cycles and flags out-of-bounds clocks.
// Define CLK_PERIOD_CHECKER_DUTY_EN to build the high-time (duty) measurement.
module clk_period_checker
  import clk_period_checker_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             en,
  input  logic [CNT_W-1:0] period_min,
  input  logic [CNT_W-1:0] period_max,
  input  logic [CNT_W-1:0] high_min,
  input  logic [CNT_W-1:0] high_max,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_vld,
  output logic             err_period,
  output logic             err_high,
  output logic             err_stuck,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic lvl, rise, fall;

  clk_period_checker_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .lvl     (lvl),
    .rise    (rise),
    .fall    (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_ctr_q, per_ctr_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_vld_q, meas_vld_d;
  logic             locked_q, locked_d;
  logic             err_period_q, err_period_d;
  logic             err_stuck_q, err_stuck_d;
  logic             per_bad, high_bad;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
  logic [CNT_W-1:0] high_ctr_q, high_ctr_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             err_high_q, err_high_d;
`else
  logic unused_duty;
  assign unused_duty = ^{high_min, high_max, lvl, fall};
`endif

  always_comb begin
    state_d      = state_q;
    per_ctr_d    = per_ctr_q;
    period_cnt_d = period_cnt_q;
    meas_vld_d   = 1'b0;
    locked_d     = locked_q;
    err_period_d = err_clr ? 1'b0 : err_period_q;
    err_stuck_d  = err_clr ? 1'b0 : err_stuck_q;
    per_bad      = (per_ctr_q < period_min) || (per_ctr_q > period_max);
    high_bad     = 1'b0;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
    high_ctr_d   = high_ctr_q;
    high_cap_d   = high_cap_q;
    high_cnt_d   = high_cnt_q;
    err_high_d   = err_clr ? 1'b0 : err_high_q;
    high_bad     = (high_cap_q < high_min) || (high_cap_q > high_max);
`endif

    if (!en) begin
      state_d   = IDLE;
      per_ctr_d = '0;
      locked_d  = 1'b0;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
      high_ctr_d = '0;
      high_cap_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        // The partial period before the first rise is discarded.
        ARM: begin
          if (rise) begin
            state_d   = MEASURE;
            per_ctr_d = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            per_ctr_d    = CNT_ONE;
            period_cnt_d = per_ctr_q;
            meas_vld_d   = 1'b1;
            locked_d     = !(per_bad || high_bad);
            if (per_bad) err_period_d = 1'b1;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
            high_cnt_d = high_cap_q;
            if (high_bad) err_high_d = 1'b1;
`endif
          end else if (per_ctr_q == CNT_MAX) begin
            err_stuck_d = 1'b1;
            locked_d    = 1'b0;
          end else begin
            per_ctr_d = per_ctr_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
      // The rise cycle itself is the first high cycle of the new phase.
      if (state_q != IDLE) begin
        if (rise)                           high_ctr_d = CNT_ONE;
        else if (lvl && high_ctr_q != CNT_MAX) high_ctr_d = high_ctr_q + CNT_ONE;
        if (fall) high_cap_d = high_ctr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      per_ctr_q    <= '0;
      period_cnt_q <= '0;
      meas_vld_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_period_q <= 1'b0;
      err_stuck_q  <= 1'b0;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
      high_ctr_q   <= '0;
      high_cap_q   <= '0;
      high_cnt_q   <= '0;
      err_high_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      per_ctr_q    <= per_ctr_d;
      period_cnt_q <= period_cnt_d;
      meas_vld_q   <= meas_vld_d;
      locked_q     <= locked_d;
      err_period_q <= err_period_d;
      err_stuck_q  <= err_stuck_d;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
      high_ctr_q   <= high_ctr_d;
      high_cap_q   <= high_cap_d;
      high_cnt_q   <= high_cnt_d;
      err_high_q   <= err_high_d;
`endif
    end
  end

  assign period_cnt = period_cnt_q;
  assign meas_vld   = meas_vld_q;
  assign locked     = locked_q;
  assign err_period = err_period_q;
  assign err_stuck  = err_stuck_q;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
  assign high_cnt   = high_cnt_q;
  assign err_high   = err_high_q;
`else
  assign high_cnt   = '0;
  assign err_high   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_checker.sv
// Directed self-checking bench for clk_period_checker (CNT_W=8, 10 ns clk).
module tb_clk_period_checker;

  localparam int unsigned CNT_W = 8;
`ifdef CLK_PERIOD_CHECKER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, mon_clk, en, err_clr;
  logic [CNT_W-1:0] period_min, period_max, high_min, high_max;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_vld, err_period, err_high, err_stuck, locked;

  int checks = 0;
  int errors = 0;

  logic mon_run = 1'b0;
  int   mon_per = 100;
  int   mon_hi  = 50;

  clk_period_checker #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mon_clk    (mon_clk),
    .en         (en),
    .period_min (period_min),
    .period_max (period_max),
    .high_min   (high_min),
    .high_max   (high_max),
    .err_clr    (err_clr),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_vld   (meas_vld),
    .err_period (err_period),
    .err_high   (err_high),
    .err_stuck  (err_stuck),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // mon_clk edges stay at 2 ns mod 10 ns, clear of the clk edges.
  initial begin
    mon_clk = 1'b0;
    #2;
    forever begin
      if (mon_run) begin
        mon_clk = 1'b1;
        #(mon_hi);
        mon_clk = 1'b0;
        #(mon_per - mon_hi);
      end else begin
        #10;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_meas(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_vld !== 1'b1 && n < 400);
    check(tag, 32'(meas_vld), 32'd1);
  endtask

  task automatic reconfig(input int per, input int hi);
    en = 1'b0;
    mon_per = per;
    mon_hi  = hi;
    repeat (30) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; err_clr = 1'b0;
    period_min = 8'd9; period_max = 8'd11;
    high_min   = 8'd4; high_max   = 8'd6;
    repeat (3) @(negedge clk);
    check("rst_period_cnt", 32'(period_cnt), 32'd0);
    check("rst_high_cnt",   32'(high_cnt),   32'd0);
    check("rst_meas_vld",   32'(meas_vld),   32'd0);
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_errs",       32'({err_period, err_high, err_stuck}), 32'd0);

    // Nominal 100 ns, 50% duty clock
    rst = 1'b0; mon_run = 1'b1; en = 1'b1;
    wait_meas("nom_meas1");
    check("nom_period_cnt", 32'(period_cnt), 32'd10);
    check("nom_high_cnt",   32'(high_cnt),   DUTY ? 32'd5 : 32'd0);
    check("nom_locked",     32'(locked),     32'd1);
    check("nom_errs",       32'({err_period, err_high, err_stuck}), 32'd0);
    @(negedge clk);
    check("nom_vld_pulse",  32'(meas_vld),   32'd0);
    wait_meas("nom_meas2");
    check("nom2_period_cnt", 32'(period_cnt), 32'd10);

    // Slow 130 ns clock: period error, then err_clr clears it
    reconfig(130, 60);
    wait_meas("slow_meas");
    check("slow_period_cnt", 32'(period_cnt), 32'd13);
    check("slow_err_period", 32'(err_period), 32'd1);
    check("slow_locked",     32'(locked),     32'd0);
    check("slow_high_cnt",   32'(high_cnt),   DUTY ? 32'd6 : 32'd0);
    check("slow_err_high",   32'(err_high),   32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("slow_clr",        32'(err_period), 32'd0);

    // err_clr held through an out-of-bounds capture: new error wins
    err_clr = 1'b1;
    wait_meas("clr_race_meas");
    check("clr_race_err",    32'(err_period), 32'd1);
    err_clr = 1'b0;

    // 30% duty at 100 ns
    reconfig(100, 30);
    wait_meas("duty_meas");
    check("duty_period_cnt", 32'(period_cnt), 32'd10);
    check("duty_high_cnt",   32'(high_cnt),   DUTY ? 32'd3 : 32'd0);
    check("duty_err_high",   32'(err_high),   DUTY ? 32'd1 : 32'd0);
    check("duty_err_period", 32'(err_period), 32'd0);
    check("duty_locked",     32'(locked),     DUTY ? 32'd0 : 32'd1);

    // Stuck clock: saturation 255 cycles after the last rise
    reconfig(100, 50);
    wait_meas("stuck_pre_meas");
    check("stuck_pre_locked", 32'(locked), 32'd1);
    mon_run = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (err_stuck !== 1'b1 && n < 400);
    check("stuck_delay",      32'(n),          32'd255);
    check("stuck_locked",     32'(locked),     32'd0);
    check("stuck_err_period", 32'(err_period), 32'd0);

    // Reset during the high phase
    mon_run = 1'b1;
    reconfig(100, 50);
    wait_meas("rst_pre_meas");
    check("rst_pre_locked", 32'(locked), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_period_cnt", 32'(period_cnt), 32'd0);
    check("mrst_high_cnt",   32'(high_cnt),   32'd0);
    check("mrst_vld_lock",   32'({meas_vld, locked}), 32'd0);
    check("mrst_errs",       32'({err_period, err_high, err_stuck}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_vld !== 1'b1 && n < 400);
    check("mrst_first_vld",  32'(n),          32'd17);
    check("mrst_period",     32'(period_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
